// File: rtl/drone_posicao_colisao_pkg.sv
// rtl/drone_posicao_colisao_pkg.sv - shared encodings, constants and obstacle maps 1-3
package drone_posicao_colisao_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        VARRE     = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    localparam logic [1:0] DIR_CIMA  = 2'b00;
    localparam logic [1:0] DIR_BAIXO = 2'b01;
    localparam logic [1:0] DIR_ESQ   = 2'b10;
    localparam logic [1:0] DIR_DIR   = 2'b11;

    localparam logic [3:0] INICIO_X  = 4'd0;
    localparam logic [3:0] INICIO_Y  = 4'd8;
    localparam logic [3:0] GRADE_MAX = 4'd15;

    localparam int             ROM_PROF = 8;
    localparam int             IDX_W    = $clog2(ROM_PROF);
    localparam logic [IDX_W-1:0] IDX_ULT = IDX_W'(ROM_PROF - 1);

    localparam logic [1:0] VIDAS_PADRAO = 2'd3;

    // Entries are {valid, x[3:0], y[3:0]}; listed from idx7 down to idx0.
    localparam logic [ROM_PROF-1:0][8:0] MAPA_1 = {
        9'h000, 9'h000, 9'h000,
        {1'b1, 4'd12, 4'd3},
        {1'b1, 4'd8,  4'd8},
        {1'b1, 4'd6,  4'd9},
        {1'b1, 4'd4,  4'd7},
        {1'b1, 4'd2,  4'd8}
    };

    localparam logic [ROM_PROF-1:0][8:0] MAPA_2 = {
        9'h000, 9'h000,
        {1'b1, 4'd15, 4'd8},
        {1'b1, 4'd0,  4'd15},
        {1'b1, 4'd4,  4'd8},
        {1'b1, 4'd9,  4'd9},
        {1'b1, 4'd15, 4'd0},
        {1'b1, 4'd1,  4'd1}
    };

    localparam logic [ROM_PROF-1:0][8:0] MAPA_3 = {
        {1'b1, 4'd15, 4'd15},
        9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
    };

endpackage

// File: rtl/drone_posicao_colisao_rom_obstaculos.sv
// rtl/drone_posicao_colisao_rom_obstaculos.sv - combinational obstacle ROM addressed by {mapa, idx}
import drone_posicao_colisao_pkg::*;

module rom_obstaculos (
    input  logic [4:0] endereco,
    output logic [8:0] dado
);

    // Map 0 is fixed here; maps 1-3 come from the shared package tables.
    always_comb begin
        dado = 9'h000;
        case (endereco[4:3])
            2'd0: begin
                case (endereco[2:0])
                    3'd0:    dado = {1'b1, 4'd3,  4'd8};
                    3'd1:    dado = {1'b1, 4'd5,  4'd4};
                    3'd2:    dado = {1'b1, 4'd7,  4'd8};
                    3'd3:    dado = {1'b1, 4'd10, 4'd2};
                    default: dado = 9'h000;
                endcase
            end
            2'd1:    dado = MAPA_1[endereco[2:0]];
            2'd2:    dado = MAPA_2[endereco[2:0]];
            default: dado = MAPA_3[endereco[2:0]];
        endcase
    end

endmodule

// File: rtl/drone_posicao_colisao.sv
// rtl/drone_posicao_colisao.sv - drone position tracker with ROM-based collision scan
import drone_posicao_colisao_pkg::*;

module drone_posicao_colisao (
    input  logic       clock,
    input  logic       reset,
    input  logic       zeraPosicoes,
    input  logic       resetaVidas,
    input  logic [1:0] vidas_ini,
    input  logic       atualiza,
    input  logic [1:0] direcao,
    input  logic       checa,
    input  logic [1:0] mapa,
    output logic       pronto,
    output logic       colisao,
    output logic       fim_mapa,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    output logic [1:0] vidas,
    output logic [1:0] db_estado
);

    estado_t          estado, estado_prox;
    logic [IDX_W-1:0] idx;
    logic [1:0]       mapa_reg;
    logic [8:0]       entrada;
    logic             acerto;

    rom_obstaculos u_rom (
        .endereco ({mapa_reg, idx}),
        .dado     (entrada)
    );

    assign acerto = entrada[8] && (entrada[7:4] == pos_x) && (entrada[3:0] == pos_y);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_prox;
    end

    // Next-state logic; zeraPosicoes aborts any scan before pronto can be issued.
    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:    if (checa) estado_prox = VARRE;
            VARRE:     if (acerto || idx == IDX_ULT) estado_prox = RESULTADO;
            RESULTADO: estado_prox = OCIOSO;
            default:   estado_prox = OCIOSO;
        endcase
        if (zeraPosicoes) estado_prox = OCIOSO;
    end

    // Outputs decoded from the state.
    always_comb begin
        pronto    = (estado == RESULTADO);
        db_estado = estado;
    end

    // Position, lives, scan index and result flags; a life reload overrides a hit decrement.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx      <= '0;
            mapa_reg <= 2'd0;
            pos_x    <= INICIO_X;
            pos_y    <= INICIO_Y;
            vidas    <= VIDAS_PADRAO;
            colisao  <= 1'b0;
            fim_mapa <= 1'b0;
        end else begin
            if (zeraPosicoes) begin
                pos_x    <= INICIO_X;
                pos_y    <= INICIO_Y;
                idx      <= '0;
                colisao  <= 1'b0;
                fim_mapa <= 1'b0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (atualiza) begin
                            case (direcao)
                                DIR_CIMA:  if (pos_y != 4'd0)    pos_y <= pos_y - 4'd1;
                                DIR_BAIXO: if (pos_y != GRADE_MAX) pos_y <= pos_y + 4'd1;
                                DIR_ESQ:   if (pos_x != 4'd0)    pos_x <= pos_x - 4'd1;
                                default:   if (pos_x != GRADE_MAX) pos_x <= pos_x + 4'd1;
                            endcase
                        end
                        if (checa) begin
                            mapa_reg <= mapa;
                            idx      <= '0;
                            colisao  <= 1'b0;
                            fim_mapa <= 1'b0;
                        end
                    end
                    VARRE: begin
                        if (acerto) begin
                            if (vidas > 2'd1) begin
                                vidas <= vidas - 2'd1;
                                pos_x <= INICIO_X;
                                pos_y <= INICIO_Y;
                            end else begin
                                vidas   <= 2'd0;
                                colisao <= 1'b1;
                            end
                        end else if (idx == IDX_ULT) begin
                            fim_mapa <= (pos_x == GRADE_MAX);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (resetaVidas) vidas <= (vidas_ini == 2'd0) ? 2'd1 : vidas_ini;
        end
    end

endmodule

// File: tb/tb_drone_posicao_colisao.sv
// tb/tb_drone_posicao_colisao.sv - self-checking bench with behavioural reference model
module tb_drone_posicao_colisao;

    logic       clock = 1'b0;
    logic       reset;
    logic       zeraPosicoes;
    logic       resetaVidas;
    logic [1:0] vidas_ini;
    logic       atualiza;
    logic [1:0] direcao;
    logic       checa;
    logic [1:0] mapa;
    logic       pronto;
    logic       colisao;
    logic       fim_mapa;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic [1:0] vidas;
    logic [1:0] db_estado;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mx, my, mv;
    int tab [4][8];

    drone_posicao_colisao dut (
        .clock        (clock),
        .reset        (reset),
        .zeraPosicoes (zeraPosicoes),
        .resetaVidas  (resetaVidas),
        .vidas_ini    (vidas_ini),
        .atualiza     (atualiza),
        .direcao      (direcao),
        .checa        (checa),
        .mapa         (mapa),
        .pronto       (pronto),
        .colisao      (colisao),
        .fim_mapa     (fim_mapa),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .vidas        (vidas),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag);
        check({tag, ".x"}, int'(pos_x), mx);
        check({tag, ".y"}, int'(pos_y), my);
    endtask

    task automatic mover(input int d);
        atualiza = 1'b1;
        direcao  = d[1:0];
        @(negedge clock);
        atualiza = 1'b0;
        case (d)
            0:       my = (my > 0)  ? my - 1 : 0;
            1:       my = (my < 15) ? my + 1 : 15;
            2:       mx = (mx > 0)  ? mx - 1 : 0;
            default: mx = (mx < 15) ? mx + 1 : 15;
        endcase
    endtask

    task automatic carrega_vidas(input int v);
        resetaVidas = 1'b1;
        vidas_ini   = v[1:0];
        @(negedge clock);
        resetaVidas = 1'b0;
        mv = (v == 0) ? 1 : v;
    endtask

    task automatic zera;
        zeraPosicoes = 1'b1;
        @(negedge clock);
        zeraPosicoes = 1'b0;
        mx = 0;
        my = 8;
    endtask

    task automatic do_checa(input int m, input string tag);
        int hit_i, elat, ecol, efim, lat;
        hit_i = -1;
        for (int i = 0; i < 8; i++)
            if (hit_i < 0 && tab[m][i] == mx * 16 + my) hit_i = i;
        ecol = 0;
        efim = 0;
        if (hit_i >= 0) begin
            elat = hit_i + 2;
            if (mv > 1) begin
                mv = mv - 1;
                mx = 0;
                my = 8;
            end else begin
                mv   = 0;
                ecol = 1;
            end
        end else begin
            elat = 9;
            efim = (mx == 15) ? 1 : 0;
        end
        checa = 1'b1;
        mapa  = m[1:0];
        @(negedge clock);
        checa = 1'b0;
        lat   = 1;
        while (!pronto && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, ".latency"}, lat, elat);
        check({tag, ".colisao"}, int'(colisao), ecol);
        check({tag, ".fim_mapa"}, int'(fim_mapa), efim);
        check({tag, ".vidas"}, int'(vidas), mv);
        check_pos(tag);
        @(negedge clock);
        check({tag, ".pronto_low"}, int'(pronto), 0);
        check({tag, ".idle"}, int'(db_estado), 0);
    endtask

    initial begin
        int cnt;
        tab[0] = '{3*16+8, 5*16+4, 7*16+8, 10*16+2, -1, -1, -1, -1};
        tab[1] = '{2*16+8, 4*16+7, 6*16+9, 8*16+8, 12*16+3, -1, -1, -1};
        tab[2] = '{1*16+1, 15*16+0, 9*16+9, 4*16+8, 0*16+15, 15*16+8, -1, -1};
        tab[3] = '{-1, -1, -1, -1, -1, -1, -1, 15*16+15};

        reset = 1'b1; zeraPosicoes = 1'b0; resetaVidas = 1'b0; vidas_ini = 2'd0;
        atualiza = 1'b0; direcao = 2'd0; checa = 1'b0; mapa = 2'd0;
        mx = 0; my = 8; mv = 3;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst.estado", int'(db_estado), 0);
        check_pos("rst");
        check("rst.vidas", int'(vidas), 3);
        check("rst.pronto", int'(pronto), 0);
        check("rst.colisao", int'(colisao), 0);
        check("rst.fim", int'(fim_mapa), 0);

        // Hit at idx0 with spare lives
        repeat (3) mover(3);
        check_pos("hit0.pre");
        do_checa(0, "hit0");

        // Fatal hit at idx1 with one life
        carrega_vidas(1);
        check("load1.vidas", int'(vidas), 1);
        repeat (5) mover(3);
        repeat (4) mover(0);
        check_pos("fatal.pre");
        do_checa(0, "fatal");

        // Saturation and end of map
        zera();
        carrega_vidas(0);
        check("load0.vidas", int'(vidas), 1);
        repeat (16) mover(2);
        check_pos("sat_left");
        repeat (20) mover(3);
        check_pos("sat_right");
        do_checa(0, "fim");
        repeat (9) mover(1);
        check_pos("sat_down");
        do_checa(3, "hit7");
        carrega_vidas(3);

        // Requests during a scan are ignored
        zera();
        checa = 1'b1; mapa = 2'd0;
        @(negedge clock);
        checa = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            if (pronto) cnt++;
            if (k == 2) begin atualiza = 1'b1; direcao = 2'd3; checa = 1'b1; end
            if (k == 3) begin atualiza = 1'b0; checa = 1'b0; end
            @(negedge clock);
        end
        check("ignore.prontos", cnt, 1);
        check_pos("ignore");
        check("ignore.idle", int'(db_estado), 0);

        // zeraPosicoes mid-scan
        mover(3);
        checa = 1'b1; mapa = 2'd0;
        @(negedge clock);
        checa = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            if (pronto) cnt++;
            if (k == 4) zeraPosicoes = 1'b1;
            if (k == 5) zeraPosicoes = 1'b0;
            @(negedge clock);
        end
        mx = 0; my = 8;
        check("zera.prontos", cnt, 0);
        check("zera.idle", int'(db_estado), 0);
        check_pos("zera");

        // Reset mid-scan
        carrega_vidas(2);
        mover(1);
        checa = 1'b1; mapa = 2'd2;
        @(negedge clock);
        checa = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            if (pronto) cnt++;
            if (k == 3) reset = 1'b1;
            if (k == 4) reset = 1'b0;
            @(negedge clock);
        end
        mx = 0; my = 8; mv = 3;
        check("rstmid.prontos", cnt, 0);
        check("rstmid.idle", int'(db_estado), 0);
        check_pos("rstmid");
        check("rstmid.vidas", int'(vidas), 3);

        // Life reload coinciding with a hit decrement
        repeat (3) mover(3);
        checa = 1'b1; mapa = 2'd0;
        @(negedge clock);
        checa = 1'b0;
        resetaVidas = 1'b1; vidas_ini = 2'd3;
        @(negedge clock);
        resetaVidas = 1'b0;
        mx = 0; my = 8; mv = 3;
        check("load_win.pronto", int'(pronto), 1);
        check("load_win.vidas", int'(vidas), 3);
        check_pos("load_win");
        @(negedge clock);

        // Simultaneous move and checa: scan uses the updated position
        atualiza = 1'b1; direcao = 2'd3;
        mx = 1;
        do_checa(1, "mvchk_hit_none");
        atualiza = 1'b0;
        carrega_vidas(3);

        // Randomized operations against the model
        for (int n = 0; n < 80; n++) begin
            int op;
            op = int'($urandom_range(0, 11));
            if (op < 7) begin
                mover((op < 3) ? 3 : int'($urandom_range(0, 3)));
                check_pos($sformatf("rnd%0d.mv", n));
            end else if (op < 10) begin
                do_checa(int'($urandom_range(0, 3)), $sformatf("rnd%0d.chk", n));
            end else if (op == 10) begin
                carrega_vidas(int'($urandom_range(0, 3)));
                check($sformatf("rnd%0d.load", n), int'(vidas), mv);
            end else begin
                zera();
                check_pos($sformatf("rnd%0d.zera", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drone_posicao_colisao.md
DRONE_POSICAO_COLISAO -- requirements
Module: drone_posicao_colisao

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: zeraPosicoes  in  1  return drone to start cell; abort any scan.
REQ-004 SHALL have port: resetaVidas  in  1  load the life counter from vidas_ini.
REQ-005 SHALL have port: vidas_ini  in  2  initial lives; 0 is treated as 1.
REQ-006 SHALL have port: atualiza  in  1  one-cycle move request.
REQ-007 SHALL have port: direcao  in  2  move direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
REQ-008 SHALL have port: checa  in  1  one-cycle collision-check request.
REQ-009 SHALL have port: mapa  in  2  obstacle map select; sampled with checa.
REQ-010 SHALL have port: pronto  out  1  one-cycle result strobe.
REQ-011 SHALL have port: colisao  out  1  fatal collision (last life lost); valid when pronto=1, held until next checa.
REQ-012 SHALL have port: fim_mapa  out  1  drone reached x=15 with no fatal collision; valid when pronto=1, held until next checa.
REQ-013 SHALL have port: pos_x, pos_y  out  4 each  current drone cell.
REQ-014 SHALL have port: vidas  out  2  remaining lives.
REQ-015 SHALL have port: db_estado  out  2  FSM state code: OCIOSO=0, VARRE=1, RESULTADO=2.

Function
REQ-016 SHALL implement an FSM with states OCIOSO, VARRE and RESULTADO.
REQ-017 In OCIOSO, checa=1 SHALL latch mapa, clear the scan index to 0, clear colisao/fim_mapa, and move the FSM to VARRE.
REQ-018 In VARRE, each cycle SHALL compare ROM entry [mapa][idx] {valid,x,y} against (pos_x,pos_y).
REQ-019 In VARRE, a hit SHALL move the FSM to RESULTADO; a miss at idx=7 SHALL move it to RESULTADO; any other miss SHALL increment idx.
REQ-020 pronto SHALL be 1 only while the FSM is in RESULTADO, which lasts exactly one cycle, after which the FSM returns to OCIOSO.
REQ-021 Latency, counted from the cycle in which checa is sampled: hit at idx i -> pronto in cycle i+2; no hit -> pronto in cycle 9.
REQ-022 On a hit with vidas>1: vidas SHALL decrement, position SHALL reset to (0,8), colisao=0, fim_mapa=0.
REQ-023 On a hit with vidas<=1: vidas SHALL become 0, position SHALL be unchanged, colisao=1, fim_mapa=0.
REQ-024 On no hit: colisao=0 and fim_mapa=(pos_x==15).
REQ-025 atualiza SHALL be acted on only in OCIOSO; the move takes effect on the next edge; coordinates saturate at 0 and 15 (no wrap).
REQ-026 atualiza or checa asserted outside OCIOSO SHALL be ignored; they are not queued.
REQ-027 If atualiza and checa are both 1 in OCIOSO, the move SHALL apply and the scan SHALL use the updated position.
REQ-028 zeraPosicoes SHALL have priority over atualiza and checa: position becomes (0,8), FSM goes to OCIOSO, pronto is not issued, colisao/fim_mapa clear.
REQ-029 resetaVidas SHALL be honoured in any state.
REQ-030 If resetaVidas coincides with a hit decrement, the load SHALL win.

Reset
REQ-031 On reset=1 at a rising clock edge, the block SHALL set: FSM=OCIOSO, idx=0, pos_x=0, pos_y=8, vidas=3, pronto=0, colisao=0, fim_mapa=0, latched mapa=0.
REQ-032 Reset SHALL override every other input.
REQ-033 Reset asserted mid-scan SHALL abort the scan without issuing pronto.

Structure
REQ-034 A shared package SHALL hold: state encodings; direction codes; start cell (0,8); grid max 15; ROM depth 8; default lives 3.
REQ-035 The design SHALL contain one sub-module, rom_obstaculos: combinational, address {mapa,idx} (5 bits), 9-bit data {valid,x[3:0],y[3:0]}.
REQ-036 rom_obstaculos map 0 SHALL contain: idx0 (3,8), idx1 (5,4), idx2 (7,8), idx3 (10,2), idx4-7 invalid.
REQ-037 rom_obstaculos maps 1-3 SHALL be defined in the package.

Verification
REQ-038 Reset; 3 atualiza with direcao=11; checa with mapa=0 -> pos=(3,8), hit at idx0, pronto 2 cycles after checa, vidas 3->2, pos back to (0,8), colisao=0.
REQ-039 resetaVidas with vidas_ini=1; move to (5,4); checa mapa=0 -> pronto at cycle 3, colisao=1, vidas=0, pos stays (5,4).
REQ-040 From (0,8): 16 atualiza with direcao=10 -> pos_x stays 0; 20 atualiza with direcao=11 -> pos_x=15; checa mapa=0 -> pronto at cycle 9, fim_mapa=1, colisao=0.
REQ-041 checa, then atualiza and a second checa during VARRE -> both ignored, exactly one pronto, position unchanged.
REQ-042 zeraPosicoes at cycle 4 of a scan -> no pronto, FSM=OCIOSO (db_estado=0), pos=(0,8).
REQ-043 reset mid-scan -> no pronto, FSM=OCIOSO, pos=(0,8), vidas=3.
